// File: rtl/tf_gen_qw_if.sv
// Bundle for the twiddle-factor generator: exponent beats in, twiddle factors out.
// Signal suffixes are from the generator's point of view (slave side).
interface tf_gen_qw_if #(
   parameter int LANES     = 4,
   parameter int LOG2N_MAX = 12,
   parameter int DW        = 32
);
   logic                         in_valid_i;
   logic                         hold_i;
   logic [3:0]                   log2n_i;
   logic                         inv_i;
   logic [LANES*LOG2N_MAX-1:0]   exp_i;
   logic                         out_valid_o;
   logic [LANES*2*DW-1:0]        tf_o;
   logic                         err_o;

   modport master (
      output in_valid_i, hold_i, log2n_i, inv_i, exp_i,
      input  out_valid_o, tf_o, err_o
   );

   modport slave (
      input  in_valid_i, hold_i, log2n_i, inv_i, exp_i,
      output out_valid_o, tf_o, err_o
   );
endinterface

// File: rtl/tf_gen_qw.sv
// Multi-lane twiddle-factor generator: quarter-wave cos/sin table per lane, rebuilt to
// W_N^k = exp(-j*2*pi*k/N) by quadrant swap/negate, run-time N and optional conjugate.
module tf_gen_qw #(
   parameter int LANES     = 4,
   parameter int LOG2N_MAX = 12,
   parameter int DW        = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   tf_gen_qw_if.slave   bus
);
   localparam int AW    = LOG2N_MAX - 2;
   localparam int DEPTH = 1 << AW;
   localparam int TW    = 2 * DW;

   // Table word r = {C,S} of angle 2*pi*r/2**LOG2N_MAX, Q2.(DW-2), rounded to nearest.
   function automatic logic [TW-1:0] tf_word(input int r);
      real ang;
      real scl;
      logic [DW-1:0] c;
      logic [DW-1:0] s;
      ang = 2.0 * 3.14159265358979323846 * real'(r) / real'(longint'(1) << LOG2N_MAX);
      scl = real'(longint'(1) << (DW - 2));
      c   = DW'(longint'($cos(ang) * scl));
      s   = DW'(longint'($sin(ang) * scl));
      return {c, s};
   endfunction

   logic [TW-1:0] rom [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = tf_word(gi);
   end

   logic       advance;
   logic       log2n_ok;
   logic [3:0] log2n_eff;
   logic [3:0] shamt;

   assign advance   = !bus.hold_i;
   assign log2n_ok  = (bus.log2n_i >= 4'd2) && (bus.log2n_i <= 4'(LOG2N_MAX));
   assign log2n_eff = log2n_ok ? bus.log2n_i : 4'(LOG2N_MAX);
   assign shamt     = 4'(LOG2N_MAX) - log2n_eff;

   logic            valid1_q;
   logic            inv1_q;
   logic            out_valid_q;
   logic            err_q;
   logic [LANES*TW-1:0] tf_q;
   wire  [LANES*TW-1:0] tf_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid1_q <= 1'b0;
         inv1_q   <= 1'b0;
      end else if (advance) begin
         valid1_q <= bus.in_valid_i;
         inv1_q   <= bus.inv_i;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LOG2N_MAX-1:0] m;
      logic [TW-1:0]        rd_q;
      logic [1:0]           quad_q;
      logic [DW-1:0]        c;
      logic [DW-1:0]        s;
      logic [DW-1:0]        re_d;
      logic [DW-1:0]        im_d;

      // Shifting within LOG2N_MAX bits discards exponent bits >= LOG2N (wrap-around).
      assign m = bus.exp_i[gi*LOG2N_MAX +: LOG2N_MAX] << shamt;

      // Read register kept reset-free so the table maps onto block RAM.
      always_ff @(posedge clk_i) begin
         if (advance) begin
            rd_q <= rom[m[AW-1:0]];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            quad_q <= 2'd0;
         end else if (advance) begin
            quad_q <= m[LOG2N_MAX-1:LOG2N_MAX-2];
         end
      end

      assign c = rd_q[TW-1:DW];
      assign s = rd_q[DW-1:0];

      always_comb begin
         re_d = c;
         im_d = -s;
         case (quad_q)
            2'd0: begin re_d = c;  im_d = -s; end
            2'd1: begin re_d = -s; im_d = -c; end
            2'd2: begin re_d = -c; im_d = s;  end
            2'd3: begin re_d = s;  im_d = c;  end
            default: ;
         endcase
         if (inv1_q) begin
            im_d = -im_d;
         end
      end

      assign tf_d[gi*TW +: TW] = {re_d, im_d};
   end

   // Output holds its last value on empty beats; ERR is sticky until reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         tf_q        <= '0;
         err_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= valid1_q;
         if (valid1_q) begin
            tf_q <= tf_d;
         end
         if (bus.in_valid_i && !log2n_ok) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.tf_o        = tf_q;
   assign bus.err_o       = err_q;
endmodule
